uart_rx_fsm: RTL and testbench

Receive-side controller of the UART RX path. It detects the start edge on the line, runs the oversampling edge/bit counters, and strobes the sampler, deserializer and the start/parity/stop checkers at the right edges. It collects the checker results and issues a one-cycle `data_valid` for each clean frame. It sits between the line synchronizer and the data_sampling / deserializer / checker stages.

---
 rtl/uart_rx_pkg.sv | 39 +++
 rtl/edge_bit_counter.sv | 48 ++++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive controller.
// Revision    : 1.0
// ============================================================================
package uart_rx_pkg;

  localparam int EDGE_W = 6;
  localparam int BIT_W  = 4;

  localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_t;

  // Unsupported oversampling ratios fall back to the slowest legal setting.
  function automatic logic [EDGE_W-1:0] map_prescale(input logic [EDGE_W-1:0] ps);
    case (ps)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

  function automatic logic is_counting(input rx_state_t s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : edge_bit_counter
// Description : Oversample edge counter and bit counter for one UART frame.
// Revision    : 1.0
// ============================================================================
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clear,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              last_edge
);

  logic [EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_last_edge;

  assign w_last_edge = (r_edge_cnt == (prescale - EDGE_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (clear) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (enable) begin
      if (w_last_edge) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
      end
    end
  end

  assign edge_cnt  = r_edge_cnt;
  assign bit_cnt   = r_bit_cnt;
  assign last_edge = w_last_edge;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART RX frame controller: start detect, counters, strobes.
// Revision    : 1.0
// ============================================================================
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic [EDGE_W-1:0] Prescale,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              dat_samp_en,
  output logic              deser_en,
  output logic              strt_chk_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              data_valid
);

  rx_state_t         r_state;
  rx_state_t         w_next_state;
  logic              r_par_en;
  logic [EDGE_W-1:0] r_prescale;

  logic [EDGE_W-1:0] w_edge_cnt;
  logic [BIT_W-1:0]  w_bit_cnt;
  logic              w_last_edge;
  logic              w_cnt_enable;
  logic              w_cnt_clear;
  logic              w_start_det;
  logic              w_glitch_abort;
  logic              w_last_data_bit;

  assign w_start_det     = (r_state == IDLE) && !RX_IN;
  assign w_glitch_abort  = (r_state == DATA) && strt_glitch &&
                           (w_edge_cnt == EDGE_W'(1)) && (w_bit_cnt == BIT_W'(1));
  assign w_last_data_bit = (w_bit_cnt == BIT_W'(DATA_WIDTH));

  // Counters run only inside the frame and are zero on entry to IDLE/CHECK.
  assign w_cnt_enable = is_counting(r_state);
  assign w_cnt_clear  = !is_counting(w_next_state);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_par_en   <= 1'b0;
      r_prescale <= PRESCALE_8;
    end else begin
      r_state <= w_next_state;
      if (w_start_det) begin
        r_par_en   <= PAR_EN;
        r_prescale <= map_prescale(Prescale);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    dat_samp_en  = 1'b0;
    deser_en     = 1'b0;
    strt_chk_en  = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    data_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!RX_IN) w_next_state = START;
      end
      START: begin
        dat_samp_en = 1'b1;
        if (w_last_edge) begin
          strt_chk_en  = 1'b1;
          w_next_state = DATA;
        end
      end
      DATA: begin
        dat_samp_en = 1'b1;
        if (w_glitch_abort) begin
          w_next_state = IDLE;
        end else if (w_last_edge) begin
          deser_en = 1'b1;
          if (w_last_data_bit) w_next_state = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        dat_samp_en = 1'b1;
        if (w_last_edge) begin
          par_chk_en   = 1'b1;
          w_next_state = STOP;
        end
      end
      STOP: begin
        dat_samp_en = 1'b1;
        if (w_last_edge) begin
          stp_chk_en   = 1'b1;
          w_next_state = CHECK;
        end
      end
      CHECK: begin
        // Checker results are registered, so both are settled in this cycle.
        data_valid   = !stp_err && (!par_err || !r_par_en);
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  edge_bit_counter u_edge_bit_counter (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (w_cnt_enable),
    .clear     (w_cnt_clear),
    .prescale  (r_prescale),
    .edge_cnt  (w_edge_cnt),
    .bit_cnt   (w_bit_cnt),
    .last_edge (w_last_edge)
  );

  assign edge_cnt = w_edge_cnt;
  assign bit_cnt  = w_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Self-checking bench for uart_rx_fsm.
// Revision    : 1.0
// ============================================================================
module tb_uart_rx_fsm;

  localparam int DW = 8;

  logic       CLK         = 1'b0;
  logic       RST         = 1'b1;
  logic       RX_IN       = 1'b1;
  logic       PAR_EN      = 1'b0;
  logic [5:0] Prescale    = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err     = 1'b0;
  logic       stp_err     = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0] ps;
    logic       par_en;
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         eff_ps;
    logic       exp_valid;
    int         gap_bits;
  } vec_t;

  typedef struct {
    int   start;
    int   exp_stp;
    logic exp_valid;
    int   ps;
    int   par;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];

  // Monitor tallies; snapshots delimit one frame.
  int   tot_deser_any = 0, tot_deser_ok = 0, tot_par_any = 0, tot_par_ok = 0;
  int   tot_strt = 0, tot_valid = 0;
  int   s_deser_any = 0, s_deser_ok = 0, s_par_any = 0, s_par_ok = 0;
  int   s_strt = 0, s_valid = 0;
  int   sync_req = 0, sync_seen = 0;
  int   stp_off = 0;
  logic pend = 1'b0;
  logic mon_on = 1'b0;
  exp_t mon_e;

  always @(negedge CLK) begin
    if (mon_on) begin
      if (sync_req != sync_seen) begin
        s_deser_any = tot_deser_any; s_deser_ok = tot_deser_ok;
        s_par_any   = tot_par_any;   s_par_ok   = tot_par_ok;
        s_strt      = tot_strt;      s_valid    = tot_valid;
        sync_seen   = sync_req;
      end
      chk("strobe_overlap",
          int'($countones({deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}) <= 1), 1);
      if (deser_en) tot_deser_any++;
      if (par_chk_en) tot_par_any++;
      if (strt_chk_en) tot_strt++;
      if (data_valid) tot_valid++;
      if (sb_q.size() > 0) begin
        if (deser_en && int'(edge_cnt) == sb_q[0].ps - 1 &&
            int'(bit_cnt) >= 1 && int'(bit_cnt) <= DW) tot_deser_ok++;
        if (par_chk_en && int'(edge_cnt) == sb_q[0].ps - 1 &&
            int'(bit_cnt) == DW + 1) tot_par_ok++;
      end
      if (pend) begin
        pend  = 1'b0;
        mon_e = sb_q.pop_front();
        chk("stp_chk_cycle", stp_off, mon_e.exp_stp);
        chk("deser_at_last_edge", tot_deser_ok - s_deser_ok, DW);
        chk("deser_pulses", tot_deser_any - s_deser_any, DW);
        chk("par_chk_at_bit9", tot_par_ok - s_par_ok, mon_e.par);
        chk("par_chk_pulses", tot_par_any - s_par_any, mon_e.par);
        chk("strt_chk_pulses", tot_strt - s_strt, 1);
        chk("data_valid", int'(data_valid), int'(mon_e.exp_valid));
        chk("data_valid_pulses", tot_valid - s_valid, int'(mon_e.exp_valid));
        s_deser_any = tot_deser_any; s_deser_ok = tot_deser_ok;
        s_par_any   = tot_par_any;   s_par_ok   = tot_par_ok;
        s_strt      = tot_strt;      s_valid    = tot_valid;
      end
      if (stp_chk_en) begin
        if (sb_q.size() == 0) chk("unexpected_stp_chk", 1, 0);
        else begin
          stp_off = cyc - sb_q[0].start;
          pend    = 1'b1;
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called at #1 after a rising edge; pushes the expectation then drives the line.
  task automatic drive_frame(input vec_t v, input int delay);
    exp_t e;
    int   n;
    n           = v.eff_ps;
    e.start     = cyc;
    e.exp_stp   = (DW + 2 + (v.par_en ? 1 : 0)) * n + delay;
    e.exp_valid = v.exp_valid;
    e.ps        = n;
    e.par       = v.par_en ? 1 : 0;
    sb_q.push_back(e);
    PAR_EN   = v.par_en;
    Prescale = v.ps;
    par_err  = v.perr;
    stp_err  = v.serr;
    drive_bit(1'b0, n);
    // Configuration changes after the latch point must have no effect.
    PAR_EN   = ~v.par_en;
    Prescale = (v.ps == 6'd16) ? 6'd8 : 6'd16;
    for (int i = 0; i < DW; i++) drive_bit(v.data[i], n);
    if (v.par_en) drive_bit(^v.data, n);
    drive_bit(~v.serr, n);
    RX_IN = 1'b1;
    if (v.gap_bits > 0) begin
      repeat (v.gap_bits * n) @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge CLK);
      k++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   prev_gap;
    int   k;
    int   base_deser;
    int   base_valid;
    logic found;

    vecs[0] = '{6'd8,  1'b0, 8'hA5, 1'b0, 1'b0, 8,  1'b1, 2};
    vecs[1] = '{6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 16, 1'b1, 2};
    vecs[2] = '{6'd8,  1'b0, 8'h5A, 1'b0, 1'b1, 8,  1'b0, 2};
    vecs[3] = '{6'd16, 1'b1, 8'h81, 1'b1, 1'b0, 16, 1'b0, 2};
    vecs[4] = '{6'd8,  1'b0, 8'hC3, 1'b1, 1'b0, 8,  1'b1, 2};
    vecs[5] = '{6'd12, 1'b0, 8'h69, 1'b0, 1'b0, 8,  1'b1, 2};
    vecs[6] = '{6'd32, 1'b0, 8'h00, 1'b0, 1'b0, 32, 1'b1, 0};
    vecs[7] = '{6'd32, 1'b0, 8'hFF, 1'b0, 1'b0, 32, 1'b1, 2};

    // Reset holds IDLE even with the line low.
    RST   = 1'b1;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_edge_cnt", int'(edge_cnt), 0);
    chk("reset_bit_cnt", int'(bit_cnt), 0);
    chk("reset_dat_samp_en", int'(dat_samp_en), 0);
    chk("reset_strobes", int'({deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST    = 1'b0;
    mon_on = 1'b1;
    @(posedge CLK);
    #1;

    prev_gap = 1;
    for (int i = 0; i < 8; i++) begin
      drive_frame(vecs[i], (prev_gap == 0) ? 2 : 0);
      prev_gap = vecs[i].gap_bits;
    end
    wait_drain(2000);

    // Two-cycle start glitch rejected through strt_glitch.
    @(posedge CLK);
    #1;
    strt_glitch = 1'b1;
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    base_deser  = tot_deser_any;
    base_valid  = tot_valid;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 100) begin
      @(negedge CLK);
      if (strt_chk_en) found = 1'b1;
      k++;
    end
    chk("glitch_strt_chk_seen", int'(found), 1);
    @(negedge CLK);
    @(negedge CLK);
    chk("glitch_abort_edge_cnt", int'(edge_cnt), 1);
    chk("glitch_abort_bit_cnt", int'(bit_cnt), 1);
    chk("glitch_abort_in_data", int'(dat_samp_en), 1);
    @(negedge CLK);
    chk("glitch_idle_edge_cnt", int'(edge_cnt), 0);
    chk("glitch_idle_bit_cnt", int'(bit_cnt), 0);
    chk("glitch_idle_samp_en", int'(dat_samp_en), 0);
    repeat (100) @(negedge CLK);
    chk("glitch_deser_pulses", tot_deser_any - base_deser, 0);
    chk("glitch_data_valid", tot_valid - base_valid, 0);
    strt_glitch = 1'b0;
    sync_req++;

    // Reset in the middle of a data bit aborts the frame.
    @(posedge CLK);
    #1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 200) begin
      @(negedge CLK);
      if (bit_cnt == 4'd4) found = 1'b1;
      k++;
    end
    chk("rst_reached_bit4", int'(found), 1);
    RST        = 1'b1;
    base_deser = tot_deser_any;
    base_valid = tot_valid;
    @(negedge CLK);
    chk("rst_mid_edge_cnt", int'(edge_cnt), 0);
    chk("rst_mid_bit_cnt", int'(bit_cnt), 0);
    chk("rst_mid_samp_en", int'(dat_samp_en), 0);
    chk("rst_mid_strobes", int'({deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    chk("rst_mid_no_deser", tot_deser_any - base_deser, 0);
    chk("rst_mid_no_valid", tot_valid - base_valid, 0);
    sync_req++;
    @(posedge CLK);
    #1;
    drive_frame(vecs[0], 0);
    wait_drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
